// File: rtl/dbus_pkg.sv
// Shared types and constants for the CPU-to-target data bus demultiplexer.
package dbus_pkg;

    localparam int N_TGT                  = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic [3:0] REGION_T0 = 4'h0;
    localparam logic [3:0] REGION_T1 = 4'h1;
    localparam logic [3:0] REGION_T2 = 4'h2;
    localparam logic [3:0] REGION_T3 = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational region decoder: top address nibble to one-hot target select.
module dbus_addr_decode
    import dbus_pkg::*;
(
    input  logic [3:0]       region,
    output logic [N_TGT-1:0] sel,
    output logic             unmapped
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sel      = '0;
        unmapped = 1'b0;
        case (region)
            REGION_T0: sel = 4'b0001;
            REGION_T1: sel = 4'b0010;
            REGION_T2: sel = 4'b0100;
            REGION_T3: sel = 4'b1000;
            default:   unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_bus_demux.sv
// Routes single CPU accesses to one of four targets and returns one completion pulse.
// Optional WAIT timeout is compiled in when DBUS_TIMEOUT_EN is defined.
module data_bus_demux
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int N_TGT          = dbus_pkg::N_TGT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,
    output logic [N_TGT-1:0]      t_req,
    output logic                  t_we,
    output logic [31:0]           t_addr,
    output logic [31:0]           t_wdata,
    input  logic [N_TGT-1:0]      t_ack,
    input  logic [32*N_TGT-1:0]   t_rdata
);

    state_t            state, state_d;
    logic [N_TGT-1:0]  dec_sel;
    logic              dec_unmapped;
    logic [N_TGT-1:0]  sel_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              ack_sel;
    logic [31:0]       lane_data;
    logic              timeout_hit;

    dbus_addr_decode u_decode (
        .region   (cpu_addr[31:28]),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    // Only the latched target's ack and read lane are ever looked at.
    always_comb begin
        ack_sel   = |(t_ack & sel_q);
        lane_data = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (sel_q[k]) lane_data = t_rdata[32*k +: 32];
        end
    end

`ifdef DBUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Fires on the last allowed WAIT cycle; an ack in that same cycle still wins.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample together.
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (cpu_req) state_d = dec_unmapped ? ST_RESP : ST_WAIT;
            ST_WAIT: if (ack_sel || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            t_we    <= 1'b0;
            t_addr  <= '0;
            t_wdata <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        sel_q   <= dec_sel;
                        t_we    <= cpu_we;
                        t_addr  <= cpu_addr;
                        t_wdata <= cpu_wdata;
                        rdata_q <= '0;
                        err_q   <= dec_unmapped;
                    end
                end
                ST_WAIT: begin
                    if (ack_sel) begin
                        rdata_q <= t_we ? 32'h0 : lane_data;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response fields are gated so they read zero outside the completion pulse.
    always_comb begin
        cpu_ready = (state == ST_RESP);
        cpu_rdata = cpu_ready ? rdata_q : 32'h0;
        cpu_err   = cpu_ready & err_q;
        t_req     = (state == ST_WAIT) ? sel_q : '0;
    end

endmodule

// File: tb/tb_data_bus_demux.sv
// Scoreboard bench for data_bus_demux: directed accesses, latency, timeout and reset cases.
module tb_data_bus_demux;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ready;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic [3:0]    t_req;
    logic          t_we;
    logic [31:0]   t_addr;
    logic [31:0]   t_wdata;
    logic [3:0]    t_ack;
    logic [127:0]  t_rdata;

    always #5 clk = ~clk;

    data_bus_demux #(.TIMEOUT_CYCLES(16), .N_TGT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .t_req     (t_req),
        .t_we      (t_we),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t_ack     (t_ack),
        .t_rdata   (t_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response per completion pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n === 1'b1) begin
            if (cpu_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", cpu_ready, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", cpu_rdata, e.rdata);
                    check("resp_err", cpu_err, e.err);
                end
            end else begin
                check("resp_zero_when_not_ready", {cpu_err, cpu_rdata}, 33'h0);
            end
        end
    end

    // One CPU access; tgt < 0 means unmapped, ack_at = 0 means the target never acks.
    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int tgt, input int ack_at,
                             input logic [31:0] ack_data, input logic [3:0] stray,
                             input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        logic [3:0] onehot;
        int         n;
        bit         done;
        onehot = (tgt < 0) ? 4'b0000 : 4'(1 << tgt);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        t_ack     = stray;
        t_rdata   = {4{32'h0BAD_F00D}};
        if (tgt >= 0) t_rdata[32*tgt +: 32] = ack_data;
        exp_q.push_back('{exp_rdata, exp_err});
        n    = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_ready === 1'b1) begin
                check({name, " latency"}, n, exp_lat);
                check({name, " t_req_in_resp"}, t_req, 4'b0000);
                done = 1'b1;
            end else begin
                check({name, " t_req"}, t_req, onehot);
                check({name, " t_cmd"}, {t_we, t_addr, t_wdata}, {we, addr, wdata});
            end
            @(negedge clk);
            t_ack = stray | ((n == ack_at) ? onehot : 4'b0000);
            if (done) begin
                cpu_req = 1'b0;
                t_ack   = 4'b0000;
            end
        end
        if (!done) check({name, " completion_timeout"}, cpu_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        t_ack     = '0;
        t_rdata   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cpu_ready, cpu_err, cpu_rdata, t_req, t_we, t_addr, t_wdata},
              103'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_access("load_t0", 1'b0, 32'h0000_0010, 32'h0, 0, 1, 32'hDEAD_BEEF, 4'b0000,
                  1'b0, 32'hDEAD_BEEF, 2);
        do_access("store_t2", 1'b1, 32'h2000_0004, 32'h1234_5678, 2, 5, 32'hFFFF_FFFF, 4'b0000,
                  1'b0, 32'h0, 6);
        do_access("load_unmapped", 1'b0, 32'h8000_0000, 32'h0, -1, 0, 32'h0, 4'b0000,
                  1'b1, 32'h0, 1);
        do_access("load_t3_stray", 1'b0, 32'h3000_0100, 32'h0, 3, 2, 32'hCAFE_0003, 4'b0001,
                  1'b0, 32'hCAFE_0003, 3);
        do_access("load_t1", 1'b0, 32'h1000_0008, 32'h0, 1, 1, 32'h1111_2222, 4'b0000,
                  1'b0, 32'h1111_2222, 2);
        do_access("store_unmapped", 1'b1, 32'hF000_0000, 32'h5555_AAAA, -1, 0, 32'h0, 4'b0000,
                  1'b1, 32'h0, 1);
        do_access("load_t0_top", 1'b0, 32'h0FFF_FFFC, 32'h0, 0, 1, 32'h0F0F_0F0F, 4'b0000,
                  1'b0, 32'h0F0F_0F0F, 2);
        do_access("load_0x4", 1'b0, 32'h4000_0000, 32'h0, -1, 0, 32'h0, 4'b0000,
                  1'b1, 32'h0, 1);

`ifdef DBUS_TIMEOUT_EN
        do_access("timeout_t1", 1'b0, 32'h1000_0000, 32'h0, 1, 0, 32'h7777_7777, 4'b0000,
                  1'b1, 32'h0, 17);
        // Late ack with no request outstanding must not produce a completion.
        @(negedge clk);
        t_ack = 4'b0010;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("late_ack_no_req", {cpu_ready, t_req}, 5'h0);
        end
        @(negedge clk);
        t_ack = 4'b0000;
        do_access("ack_on_last_wait", 1'b0, 32'h1000_0004, 32'h0, 1, 16, 32'h1616_1616, 4'b0000,
                  1'b0, 32'h1616_1616, 17);
`else
        do_access("long_wait_t1", 1'b0, 32'h1000_0000, 32'h0, 1, 20, 32'h2020_2020, 4'b0000,
                  1'b0, 32'h2020_2020, 21);
`endif

        // Asynchronous reset in the middle of a target 3 WAIT, with a stray ack on target 0.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h3000_0040;
        cpu_wdata = 32'hA5A5_5A5A;
        t_ack     = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check("mid_wait_t_req", t_req, 4'b1000);
        check("mid_wait_no_ready", cpu_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {cpu_ready, cpu_err, cpu_rdata, t_req, t_we, t_addr, t_wdata}, 103'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        t_ack   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        do_access("after_reset_t3", 1'b0, 32'h3000_0044, 32'h0, 3, 1, 32'h3333_4444, 4'b0000,
                  1'b0, 32'h3333_4444, 2);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_demux.md
DATA_BUS_DEMUX -- requirements
Module: data_bus_demux

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of WAIT cycles before a request is abandoned (legal range 2..255).
REQ-002 Parameter N_TGT, default 4, SHALL set the number of targets; it is fixed at 4 in this revision.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cpu_req  input  1  CPU access request, held high until cpu_ready.
REQ-006 cpu_we  input  1  1 = store, 0 = load.
REQ-007 cpu_addr  input  32  byte address.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_ready  output  1  one-cycle completion pulse.
REQ-010 cpu_rdata  output  32  load data, valid while cpu_ready is high.
REQ-011 cpu_err  output  1  error flag, valid while cpu_ready is high.
REQ-012 t_req  output  4  one-hot request to target k.
REQ-013 t_we, t_addr, t_wdata  output  1/32/32  shared target command, registered copies of the CPU fields.
REQ-014 t_ack  input  4  per-target completion.
REQ-015 t_rdata  input  128  target k's read data on bits [32k+31:32k].

Function
REQ-016 Decode SHALL use cpu_addr[31:28]: 4'h0 -> target 0 (data memory), 4'h1 -> 1, 4'h2 -> 2, 4'h3 -> 3, any other value -> unmapped.
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-018 In IDLE with cpu_req=1, the block SHALL latch we/addr/wdata and the decoded target; a mapped target goes to WAIT, an unmapped one goes to RESP with err=1 and rdata=0.
REQ-019 In WAIT, t_req[sel] SHALL be high and all other t_req bits low; t_we/t_addr/t_wdata SHALL stay stable.
REQ-020 In WAIT, t_ack[sel]=1 SHALL capture t_rdata[sel] (loads) or 0 (stores), drop t_req the next cycle, and move to RESP with err=0.
REQ-021 t_ack bits of non-selected targets SHALL be ignored in every state.
REQ-022 RESP SHALL assert cpu_ready for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-023 Latency: request seen in IDLE at cycle N; t_req high at N+1; ack at N+1 gives cpu_ready at N+2. Minimum latency is 2 cycles; unmapped accesses take 1 cycle.
REQ-024 A WAIT cycle counter (8-bit) SHALL clear on entry to WAIT; when it reaches TIMEOUT_CYCLES without an ack, t_req drops and the FSM moves to RESP with err=1 and rdata=0.
REQ-025 If the ack and the timeout occur in the same cycle, the ack SHALL win (err=0).
REQ-026 cpu_rdata and cpu_err SHALL be 0 whenever cpu_ready=0.
REQ-027 A late ack arriving after a timeout or in IDLE SHALL be ignored.

Reset
REQ-028 On rst_n=0, at any point including mid-transaction, the FSM SHALL go to IDLE, with t_req=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, t_we=0, t_addr=0, t_wdata=0 and counter=0.
REQ-029 After rst_n deasserts, the first request SHALL be accepted no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro DBUS_TIMEOUT_EN defined: REQ-024/025 SHALL be active.
REQ-031 Macro not defined: no counter SHALL exist, WAIT SHALL last until the selected ack, and cpu_err SHALL be set only for unmapped addresses.

Structure
REQ-032 Package dbus_pkg SHALL hold the FSM state enum, the region constants (4'h0..4'h3), N_TGT and the default TIMEOUT_CYCLES.
REQ-033 Sub-module dbus_addr_decode SHALL be purely combinational (address -> one-hot target plus unmapped flag) and instantiated once.

Verification
REQ-034 Load at 0x0000_0010, target 0 acks at N+1 with 0xDEAD_BEEF -> cpu_ready at N+2, cpu_rdata=0xDEAD_BEEF, cpu_err=0, t_req=4'b0001 for 1 cycle.
REQ-035 Store at 0x2000_0004, wdata 0x1234_5678, target 2 acks after 5 cycles -> t_req=4'b0100, t_wdata=0x1234_5678 stable throughout, cpu_ready once, err=0.
REQ-036 Load at 0x8000_0000 -> cpu_ready at N+1, err=1, rdata=0, t_req never asserted.
REQ-037 DBUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, target 1 never acks -> t_req[1] drops after 16 WAIT cycles, cpu_ready with err=1; a stray t_ack[1] afterwards is ignored; ack exactly on cycle 16 -> err=0.
REQ-038 rst_n pulled low during WAIT on target 3 -> all outputs 0 asynchronously, FSM in IDLE, next request completes normally; stray t_ack[0] during a target 3 access has no effect.
